// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, sizing helpers and FSM states for the conv window MAC
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Elements in one window: columns x rows x channels
    function automatic int calc_n(input int kw, input int kh, input int ch);
        return kw * kh * ch;
    endfunction

    // Number of MAC passes needed to cover n elements with the given lane count
    function automatic int calc_p(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    // Accumulator width wide enough that a full window of products cannot overflow
    function automatic int calc_acc_w(input int in_bits, input int n);
        return 2 * in_bits + clog2(n) + 1;
    endfunction

endpackage

// File: rtl/conv_window_mac_if.sv
// rtl/conv_window_mac_if.sv - window/weight input and result output handshake bundle
interface conv_window_mac_if
    import cnn_pkg::*;
#(
    parameter int IN_BIT_SIZE  = 8,
    parameter int OUT_BIT_SIZE = 20,
    parameter int N            = calc_n(4, 3, 2)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [N*IN_BIT_SIZE-1:0]    X;
    logic [N*IN_BIT_SIZE-1:0]    KERNEL;
    logic [OUT_BIT_SIZE-1:0]     BIAS;
    logic                        relu_en;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_BIT_SIZE-1:0]     result;
    logic                        saturated;

    // Window generator and feature-map writer side
    modport master (
        output in_valid, X, KERNEL, BIAS, relu_en, out_ready,
        input  in_ready, out_valid, result, saturated
    );

    // MAC block side
    modport slave (
        input  in_valid, X, KERNEL, BIAS, relu_en, out_ready,
        output in_ready, out_valid, result, saturated
    );
endinterface

// File: rtl/conv_mac_lane.sv
// rtl/conv_mac_lane.sv - LANES signed multipliers feeding one summed partial product
module conv_mac_lane
    import cnn_pkg::*;
#(
    parameter int IN_BIT_SIZE = 8,
    parameter int LANES       = 4,
    parameter int SUM_W       = 2 * IN_BIT_SIZE + clog2(LANES)
) (
    input  logic [LANES*IN_BIT_SIZE-1:0] x_lanes,
    input  logic [LANES*IN_BIT_SIZE-1:0] k_lanes,
    input  logic [LANES-1:0]             lane_en,
    output logic signed [SUM_W-1:0]      sum
);
    localparam int PROD_W = 2 * IN_BIT_SIZE;

    logic signed [PROD_W-1:0] prod [LANES];

    // Full-width signed product per lane; padding lanes contribute zero
    always_comb begin
        logic signed [PROD_W-1:0] xe;
        logic signed [PROD_W-1:0] ke;
        xe = '0;
        ke = '0;
        for (int l = 0; l < LANES; l++) begin
            xe      = PROD_W'($signed(x_lanes[l*IN_BIT_SIZE +: IN_BIT_SIZE]));
            ke      = PROD_W'($signed(k_lanes[l*IN_BIT_SIZE +: IN_BIT_SIZE]));
            prod[l] = lane_en[l] ? xe * ke : '0;
        end
    end

    // Sign-extend each product and reduce to a single partial sum
    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            sum = sum + SUM_W'(prod[l]);
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - multi-cycle window dot product with bias, ReLU and saturation
module conv_window_mac
    import cnn_pkg::*;
#(
    parameter int IN_BIT_SIZE   = 8,
    parameter int OUT_BIT_SIZE  = 20,
    parameter int KERNEL_WIDTH  = 4,
    parameter int KERNEL_HEIGHT = 3,
    parameter int CHANNELS      = 2,
    parameter int LANES         = 4
) (
    input  logic              clk,
    input  logic              reset,
    conv_window_mac_if.slave  bus
);
    localparam int N      = calc_n(KERNEL_WIDTH, KERNEL_HEIGHT, CHANNELS);
    localparam int P      = calc_p(N, LANES);
    localparam int ACC_W  = calc_acc_w(IN_BIT_SIZE, N);
    localparam int LANE_W = 2 * IN_BIT_SIZE + clog2(LANES);
    localparam int CNT_W  = (clog2(P) > 0) ? clog2(P) : 1;
    localparam int V_W    = ((ACC_W > OUT_BIT_SIZE) ? ACC_W : OUT_BIT_SIZE) + 1;
    localparam int CHUNK  = LANES * IN_BIT_SIZE;
    localparam int PAD_W  = P * CHUNK;

    localparam logic signed [V_W-1:0] MAX_V =
        {{(V_W-OUT_BIT_SIZE+1){1'b0}}, {(OUT_BIT_SIZE-1){1'b1}}};
    localparam logic signed [V_W-1:0] MIN_V =
        {{(V_W-OUT_BIT_SIZE+1){1'b1}}, {(OUT_BIT_SIZE-1){1'b0}}};

    state_t                         state_q, state_d;
    logic [N*IN_BIT_SIZE-1:0]       x_q, x_d, k_q, k_d;
    logic signed [OUT_BIT_SIZE-1:0] bias_q, bias_d;
    logic                           relu_q, relu_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]               pass_q, pass_d;
    logic [OUT_BIT_SIZE-1:0]        result_q, result_d;
    logic                           sat_q, sat_d;

    logic [PAD_W-1:0]               x_pad, k_pad;
    logic [CHUNK-1:0]               lane_x, lane_k;
    logic [LANES-1:0]               lane_en;
    logic signed [LANE_W-1:0]       lane_sum;
    logic signed [V_W-1:0]          v;

    // Zero-pad operands to whole passes and pick the slice for the current pass
    always_comb begin
        x_pad   = PAD_W'(x_q);
        k_pad   = PAD_W'(k_q);
        lane_x  = '0;
        lane_k  = '0;
        lane_en = '0;
        for (int p = 0; p < P; p++) begin
            if (pass_q == CNT_W'(p)) begin
                lane_x = x_pad[p*CHUNK +: CHUNK];
                lane_k = k_pad[p*CHUNK +: CHUNK];
                for (int l = 0; l < LANES; l++) begin
                    lane_en[l] = (p * LANES + l < N);
                end
            end
        end
    end

    conv_mac_lane #(
        .IN_BIT_SIZE (IN_BIT_SIZE),
        .LANES       (LANES),
        .SUM_W       (LANE_W)
    ) u_lane (
        .x_lanes (lane_x),
        .k_lanes (lane_k),
        .lane_en (lane_en),
        .sum     (lane_sum)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: accept, P passes, finalise, wait for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)               state_d = MAC;
            MAC:     if (pass_q == CNT_W'(P - 1))    state_d = FINAL;
            FINAL:                                   state_d = OUT;
            OUT:     if (bus.out_ready)              state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == OUT);
        bus.result    = result_q;
        bus.saturated = sat_q;
    end

    // Operand capture, accumulation and bias/ReLU/saturation of the final value
    always_comb begin
        x_d      = x_q;
        k_d      = k_q;
        bias_d   = bias_q;
        relu_d   = relu_q;
        acc_d    = acc_q;
        pass_d   = pass_q;
        result_d = result_q;
        sat_d    = sat_q;

        v = V_W'(acc_q) + V_W'(bias_q);
        if (relu_q && v[V_W-1]) v = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d    = bus.X;
                    k_d    = bus.KERNEL;
                    bias_d = bus.BIAS;
                    relu_d = bus.relu_en;
                    acc_d  = '0;
                    pass_d = '0;
                end
            end
            MAC: begin
                acc_d  = acc_q + ACC_W'(lane_sum);
                pass_d = pass_q + CNT_W'(1);
            end
            FINAL: begin
                if (v > MAX_V) begin
                    result_d = MAX_V[OUT_BIT_SIZE-1:0];
                    sat_d    = 1'b1;
                end else if (v < MIN_V) begin
                    result_d = MIN_V[OUT_BIT_SIZE-1:0];
                    sat_d    = 1'b1;
                end else begin
                    result_d = v[OUT_BIT_SIZE-1:0];
                    sat_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q      <= '0;
            k_q      <= '0;
            bias_q   <= '0;
            relu_q   <= 1'b0;
            acc_q    <= '0;
            pass_q   <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            k_q      <= k_d;
            bias_q   <= bias_d;
            relu_q   <= relu_d;
            acc_q    <= acc_d;
            pass_q   <= pass_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - three lane configurations driven in lockstep against a reference model
module tb_conv_window_mac;
    localparam int IN  = 8;
    localparam int OUT = 20;
    localparam int N   = 24;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              in_valid, out_ready, relu_en;
    logic [N*IN-1:0]   X, KERNEL;
    logic [OUT-1:0]    BIAS;

    logic [2:0]             ov, ir, sat_v;
    logic signed [OUT-1:0]  res [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 5 : 24);
        conv_window_mac_if #(.IN_BIT_SIZE(IN), .OUT_BIT_SIZE(OUT), .N(N)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.X         = X;
        assign bus.KERNEL    = KERNEL;
        assign bus.BIAS      = BIAS;
        assign bus.relu_en   = relu_en;
        assign bus.out_ready = out_ready;
        assign ov[g]    = bus.out_valid;
        assign ir[g]    = bus.in_ready;
        assign sat_v[g] = bus.saturated;
        assign res[g]   = bus.result;
        conv_window_mac #(.LANES(L)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    int n_pass  = 0;
    int n_total = 0;

    int xa [N];
    int ka [N];
    int bias_i;
    bit relu_i;

    function automatic int lanes_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 5 : 24);
    endfunction

    function automatic int passes_of(input int i);
        return (N + lanes_of(i) - 1) / lanes_of(i);
    endfunction

    // Reference: plain integer dot product, bias, optional ReLU, clamp to OUT bits
    function automatic longint model(output bit sat);
        longint acc;
        longint v;
        acc = 0;
        for (int i = 0; i < N; i++) acc += longint'(xa[i]) * longint'(ka[i]);
        v = acc + longint'(bias_i);
        if (relu_i && v < 0) v = 0;
        sat = 1'b0;
        if (v > 524287) begin
            v = 524287;
            sat = 1'b1;
        end else if (v < -524288) begin
            v = -524288;
            sat = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic fill(input int xv, input int kv);
        for (int i = 0; i < N; i++) begin
            xa[i] = xv;
            ka[i] = kv;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            xa[i] = int'($urandom_range(0, 255)) - 128;
            ka[i] = int'($urandom_range(0, 255)) - 128;
        end
        bias_i = int'($urandom_range(0, 1048575)) - 524288;
        relu_i = bit'($urandom_range(0, 1));
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            X[i*IN +: IN]      = xa[i][IN-1:0];
            KERNEL[i*IN +: IN] = ka[i][IN-1:0];
        end
        BIAS    = bias_i[OUT-1:0];
        relu_en = relu_i;
    endtask

    // Present one transaction, return just after its accept edge with inputs scrambled
    task automatic accept();
        int waited;
        waited = 0;
        @(negedge clk);
        while (ir != 3'b111 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", ir, 3'b111);
        drive_inputs();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X        = ~X;
        KERNEL   = ~KERNEL;
        BIAS     = ~BIAS;
        relu_en  = ~relu_en;
    endtask

    // Count edges from accept to out_valid per instance and compare the result
    task automatic collect(input longint exp_res, input bit exp_sat);
        int                 lat  [3];
        logic signed [63:0] r    [3];
        logic               s    [3];
        bit                 seen [3];
        for (int i = 0; i < 3; i++) begin
            lat[i]  = -1;
            r[i]    = '0;
            s[i]    = 1'b0;
            seen[i] = 1'b0;
        end
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (seen[i] && e == lat[i] + 1)
                    check($sformatf("ov_one_cycle_L%0d", lanes_of(i)), ov[i], 0);
                if (ov[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = e;
                    r[i]    = res[i];
                    s[i]    = sat_v[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("latency_L%0d", lanes_of(i)), lat[i], passes_of(i) + 1);
            check($sformatf("result_L%0d", lanes_of(i)), r[i], exp_res);
            check($sformatf("saturated_L%0d", lanes_of(i)), s[i], exp_sat);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_in_ready_L%0d", tag, lanes_of(i)), ir[i], 1);
            check($sformatf("%s_out_valid_L%0d", tag, lanes_of(i)), ov[i], 0);
            check($sformatf("%s_result_L%0d", tag, lanes_of(i)), res[i], 0);
            check($sformatf("%s_saturated_L%0d", tag, lanes_of(i)), sat_v[i], 0);
        end
    endtask

    initial begin
        longint exp_r;
        bit     exp_s;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        X         = '0;
        KERNEL    = '0;
        BIAS      = '0;
        relu_en   = 1'b0;
        bias_i    = 0;
        relu_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;

        // Basic all-ones window
        fill(1, 1); bias_i = 0; relu_i = 1'b0;
        accept(); collect(24, 1'b0);

        // Negative result, then clamped by ReLU
        fill(127, -128); bias_i = 0; relu_i = 1'b0;
        accept(); collect(-390144, 1'b0);
        relu_i = 1'b1;
        accept(); collect(0, 1'b0);

        // Positive and negative saturation
        fill(-128, -128); bias_i = 200000; relu_i = 1'b0;
        accept(); collect(524287, 1'b1);
        fill(127, -128); bias_i = -524288; relu_i = 1'b0;
        accept(); collect(-524288, 1'b1);

        // Ramp window exercises the partial last pass
        for (int i = 0; i < N; i++) begin
            xa[i] = i + 1;
            ka[i] = 1;
        end
        bias_i = 0; relu_i = 1'b0;
        accept(); collect(300, 1'b0);

        // Backpressure: result held, busy block ignores a second request
        fill(2, 3); bias_i = 5; relu_i = 1'b0;
        out_ready = 1'b0;
        accept();
        fill(0, 3);
        drive_inputs();
        in_valid = 1'b1;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", ir, 3'b000);
            for (int i = 0; i < 3; i++) begin
                if (cyc >= passes_of(i) + 1) begin
                    check($sformatf("bp_out_valid_L%0d", lanes_of(i)), ov[i], 1);
                    check($sformatf("bp_result_L%0d", lanes_of(i)), res[i], 149);
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", ov, 3'b000);
        check("bp_release_in_ready", ir, 3'b111);
        @(posedge clk);
        #1;
        check("bp_second_accept", ir, 3'b000);
        in_valid = 1'b0;
        collect(5, 1'b0);

        // Asynchronous reset in the middle of the MAC passes
        fill_random();
        accept();
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        fill_random();
        exp_r = model(exp_s);
        accept(); collect(exp_r, exp_s);

        // Randomised windows against the reference
        for (int t = 0; t < 8; t++) begin
            fill_random();
            exp_r = model(exp_s);
            accept(); collect(exp_r, exp_s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
